// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state/grant encodings and default widths for the data-memory arbiter
package dmem_arb_pkg;
  typedef enum logic {ST_CORE = 1'b0, ST_EXT = 1'b1} state_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_CORE, GNT_EXT} gnt_e;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_MAX_BURST = 4;
  localparam int DEF_MAX_WAIT  = 8;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: external (loader/debug) memory port, master drives requests, slave answers
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic              we;
  logic              last;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  modport master (output valid, we, last, addr, wdata, input ready, rdata, rvalid);
  modport slave  (input valid, we, last, addr, wdata, output ready, rdata, rvalid);
endinterface

// File: rtl/dmem_arb_cnt.sv
// dmem_arb_cnt: clear/increment counter with terminal-count flag, async active-low reset
module dmem_arb_cnt #(
  parameter int W  = 3,
  parameter int TC = 3
) (
  input  logic clk,
  input  logic Reset_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);
  logic [W-1:0] cnt_d, cnt_q;
  // clear wins over increment
  always_comb cnt_d = clr ? '0 : inc ? cnt_q + 1'b1 : cnt_q;
  // count register
  always_ff @(posedge clk or negedge Reset_n)
    if (!Reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  assign tc = cnt_q == W'(TC);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between core load/store and an external burst port; optional DMEM_ARB_FAIRNESS_EN
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int MAX_WAIT  = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  dmem_arbiter_if.slave     ext,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ext_owner
);
  localparam int BW = $clog2(MAX_BURST) + 1;
  state_e            state_q, state_d;
  gnt_e              gnt;
  logic              hold_q, hold_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ext_g, core_g, beat_tc, starve;
  // grant, next state and memory mux; beat_tc in ST_CORE only fires when MAX_BURST==1
  always_comb begin
    gnt       = (state_q == ST_EXT ? ext.valid : ext.valid && !hold_q && (!core_req || starve)) ? GNT_EXT :
                core_req ? GNT_CORE : GNT_NONE;
    ext_g     = gnt == GNT_EXT;
    core_g    = gnt == GNT_CORE;
    state_d   = ext_g ? (ext.last || beat_tc ? ST_CORE : ST_EXT) : state_q;
    hold_d    = ext_g && !ext.last && beat_tc;
    rvalid_d  = ext_g && !ext.we;
    rdata_d   = rvalid_d ? mem_rdata : rdata_q;
    mem_addr  = ext_g ? ext.addr : core_addr;
    mem_wdata = ext_g ? ext.wdata : core_wdata;
    mem_write = Reset_n && (ext_g ? ext.we : core_g && core_we);
    mem_read  = Reset_n && (ext_g ? !ext.we : core_g && !core_we);
  end
  // ownership state, post-burst hold and registered ext read return
  always_ff @(posedge clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q  <= ST_CORE;
      hold_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  dmem_arb_cnt #(.W(BW), .TC(MAX_BURST - 1)) u_beat_cnt (
    .clk, .Reset_n, .clr(state_d == ST_CORE), .inc(ext_g), .tc(beat_tc)
  );
`ifdef DMEM_ARB_FAIRNESS_EN
  dmem_arb_cnt #(.W($clog2(MAX_WAIT + 1)), .TC(MAX_WAIT)) u_wait_cnt (
    .clk, .Reset_n, .clr(ext_g), .inc(ext.valid && !ext_g && !starve), .tc(starve)
  );
`else
  logic unused_max_wait;
  assign unused_max_wait = |MAX_WAIT;
  assign starve = 1'b0;
`endif
  assign ext.ready  = Reset_n && ext_g;
  assign ext.rvalid = rvalid_q;
  assign ext.rdata  = rdata_q;
  assign core_rdata = mem_rdata;
  assign core_stall = Reset_n && core_req && !core_g;
  assign ext_owner  = state_q == ST_EXT;
endmodule
